// File: rtl/div_rr_scheduler.sv
// Round-robin front end that shares one fixed-latency 16/8 pipelined divider among NREQ requesters.
// A tag pipeline aligned to the divider latency routes each quotient back with divide-by-zero and overflow flags.
module div_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]    req_b,
    output logic [15:0]          div_a,
    output logic [7:0]           div_b,
    input  logic [7:0]           div_q,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [7:0]           rsp_q,
    output logic                 rsp_dz,
    output logic                 rsp_ovf,
    output logic [2:0]           inflight,
    output logic [15:0]          issue_cnt
);

    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            hi_found_s, lo_found_s, found_s;
    logic [IDW-1:0]  hi_id_s, lo_id_s;
    logic            grant_any_s;
    logic [IDW-1:0]  grant_id_s;
    logic [NREQ-1:0] grant_s;
    logic [15:0]     div_a_s;
    logic [7:0]      div_b_s;
    logic            dz_s, ovf_s;

    logic            tag_valid_q [LAT];
    logic            tag_valid_d [LAT];
    logic [IDW-1:0]  tag_id_q    [LAT];
    logic [IDW-1:0]  tag_id_d    [LAT];
    logic            tag_dz_q    [LAT];
    logic            tag_dz_d    [LAT];
    logic            tag_ovf_q   [LAT];
    logic            tag_ovf_d   [LAT];

    logic            rsp_fire_s;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [7:0]      rsp_quo_q, rsp_quo_d;
    logic            rsp_dz_q, rsp_dz_d;
    logic            rsp_ovf_q, rsp_ovf_d;
    logic [2:0]      inflight_q, inflight_d;
    logic [15:0]     issue_cnt_q, issue_cnt_d;

    // Arbiter: first valid above ptr wins, otherwise first valid at or below ptr.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_id_s    = '0;
        lo_id_s    = '0;
        for (int i = 0; i < NREQ; i++) begin
            hi_id_s    = (!hi_found_s && req_valid[i] && (i > int'(ptr_q))) ? IDW'(i) : hi_id_s;
            hi_found_s = hi_found_s | (req_valid[i] && (i > int'(ptr_q)));
            lo_id_s    = (!lo_found_s && req_valid[i]) ? IDW'(i) : lo_id_s;
            lo_found_s = lo_found_s | req_valid[i];
        end
        found_s     = hi_found_s | lo_found_s;
        grant_id_s  = hi_found_s ? hi_id_s : lo_id_s;
        grant_any_s = found_s & ~hold & ~rst;
        grant_s     = grant_any_s ? (NREQ'(1) << grant_id_s) : '0;
    end

    // Operand mux toward the divider plus issue-time flag evaluation.
    always_comb begin
        div_a_s = 16'h0000;
        div_b_s = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            div_a_s = (grant_any_s && (grant_id_s == IDW'(i))) ? req_a[16*i +: 16] : div_a_s;
            div_b_s = (grant_any_s && (grant_id_s == IDW'(i))) ? req_b[8*i +: 8]   : div_b_s;
        end
        dz_s  = (div_b_s == 8'h00);
        ovf_s = !dz_s && (div_a_s[15:8] >= div_b_s);
    end

    // Tag pipeline shifts every cycle; stage 0 records a bubble as valid=0.
    always_comb begin
        tag_valid_d[0] = grant_any_s;
        tag_id_d[0]    = grant_id_s;
        tag_dz_d[0]    = dz_s;
        tag_ovf_d[0]   = ovf_s;
        for (int s = 1; s < LAT; s++) begin
            tag_valid_d[s] = tag_valid_q[s-1];
            tag_id_d[s]    = tag_id_q[s-1];
            tag_dz_d[s]    = tag_dz_q[s-1];
            tag_ovf_d[s]   = tag_ovf_q[s-1];
        end
    end

    // Response capture, pointer, and counters; response fields hold when idle.
    always_comb begin
        rsp_fire_s  = tag_valid_q[LAT-1];
        rsp_valid_d = rsp_fire_s ? (NREQ'(1) << tag_id_q[LAT-1]) : '0;
        rsp_id_d    = rsp_fire_s ? tag_id_q[LAT-1] : rsp_id_q;
        rsp_dz_d    = rsp_fire_s ? tag_dz_q[LAT-1] : rsp_dz_q;
        rsp_ovf_d   = rsp_fire_s ? tag_ovf_q[LAT-1] : rsp_ovf_q;
        rsp_quo_d   = rsp_fire_s ? ((tag_dz_q[LAT-1] || tag_ovf_q[LAT-1]) ? 8'hFF : div_q) : rsp_quo_q;
        inflight_d  = inflight_q + {2'b00, grant_any_s} - {2'b00, rsp_fire_s};
        issue_cnt_d = issue_cnt_q + {15'd0, grant_any_s};
        ptr_d       = grant_any_s ? grant_id_s : ptr_q;
    end

    // State registers with synchronous reset; reset drops all in-flight tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= IDW'(NREQ-1);
            rsp_valid_q <= '0;
            rsp_id_q    <= '0;
            rsp_quo_q   <= 8'h00;
            rsp_dz_q    <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            inflight_q  <= 3'd0;
            issue_cnt_q <= 16'h0000;
            for (int s = 0; s < LAT; s++) begin
                tag_valid_q[s] <= 1'b0;
                tag_id_q[s]    <= '0;
                tag_dz_q[s]    <= 1'b0;
                tag_ovf_q[s]   <= 1'b0;
            end
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_quo_q   <= rsp_quo_d;
            rsp_dz_q    <= rsp_dz_d;
            rsp_ovf_q   <= rsp_ovf_d;
            inflight_q  <= inflight_d;
            issue_cnt_q <= issue_cnt_d;
            for (int s = 0; s < LAT; s++) begin
                tag_valid_q[s] <= tag_valid_d[s];
                tag_id_q[s]    <= tag_id_d[s];
                tag_dz_q[s]    <= tag_dz_d[s];
                tag_ovf_q[s]   <= tag_ovf_d[s];
            end
        end
    end

    assign req_ready = grant_s;
    assign div_a     = div_a_s;
    assign div_b     = div_b_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_q     = rsp_quo_q;
    assign rsp_dz    = rsp_dz_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign inflight  = inflight_q;
    assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_div_rr_scheduler.sv
// Bench for div_rr_scheduler: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_div_rr_scheduler;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 4;

    logic                clk = 1'b0;
    logic                rst, hold;
    logic [NREQ-1:0]     req_valid, req_ready;
    logic [16*NREQ-1:0]  req_a;
    logic [8*NREQ-1:0]   req_b;
    logic [15:0]         div_a;
    logic [7:0]          div_b, div_q;
    logic [NREQ-1:0]     rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [7:0]          rsp_q;
    logic                rsp_dz, rsp_ovf;
    logic [2:0]          inflight;
    logic [15:0]         issue_cnt;

    logic [15:0] a_arr [NREQ];
    logic [7:0]  b_arr [NREQ];
    logic [7:0]  dq    [LAT];

    always #5 clk = ~clk;

    div_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .div_a(div_a), .div_b(div_b), .div_q(div_q),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q),
        .rsp_dz(rsp_dz), .rsp_ovf(rsp_ovf),
        .inflight(inflight), .issue_cnt(issue_cnt)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = a_arr[i];
            req_b[8*i +: 8]   = b_arr[i];
        end
    end

    // External divider: LAT-register pipeline, no reset, no stall.
    always @(posedge clk) begin
        dq[0] <= (div_b != 8'h00) ? 8'(div_a / div_b) : 8'h00;
        for (int s = 1; s < LAT; s++) dq[s] <= dq[s-1];
    end
    assign div_q = dq[LAT-1];

    typedef struct {
        int         due;
        int         id;
        logic [7:0] q;
        logic       dz;
        logic       ovf;
    } exp_t;

    exp_t            pend [$];
    int              m_ptr, cyc;
    logic [NREQ-1:0] e_rsp_valid;
    int              e_rsp_id;
    logic [7:0]      e_rsp_q;
    logic            e_dz, e_ovf;
    logic [15:0]     e_cnt;
    int              sv_g;
    logic            sv_rst;
    logic [15:0]     sv_a;
    logic [7:0]      sv_b;
    int              n_vec = 0;
    int              n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_grant();
        if (rst || hold) return -1;
        for (int d = 1; d <= NREQ; d++) begin
            if (req_valid[(m_ptr + d) % NREQ]) return (m_ptr + d) % NREQ;
        end
        return -1;
    endfunction

    // Combinational outputs checked after inputs settle.
    task automatic settle();
        #1;
        sv_g   = model_grant();
        sv_rst = rst;
        if (sv_g >= 0) begin
            sv_a = a_arr[sv_g];
            sv_b = b_arr[sv_g];
            chk("req_ready", req_ready, 32'd1 << sv_g);
        end else begin
            sv_a = 16'h0000;
            sv_b = 8'h00;
            chk("req_ready", req_ready, 32'd0);
        end
        chk("div_a", div_a, sv_a);
        chk("div_b", div_b, sv_b);
    endtask

    // Advance model one edge, then compare registered outputs.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (sv_rst) begin
            pend.delete();
            m_ptr = NREQ - 1;
            e_cnt = 16'h0000;
            e_rsp_valid = '0;
            e_rsp_id = 0;
            e_rsp_q = 8'h00;
            e_dz = 1'b0;
            e_ovf = 1'b0;
        end else begin
            e_rsp_valid = '0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                exp_t r;
                r = pend.pop_front();
                e_rsp_valid = NREQ'(1) << r.id;
                e_rsp_id = r.id;
                e_rsp_q = r.q;
                e_dz = r.dz;
                e_ovf = r.ovf;
            end
            if (sv_g >= 0) begin
                exp_t n;
                n.due = cyc + LAT;
                n.id  = sv_g;
                n.dz  = (sv_b == 8'h00);
                n.ovf = !n.dz && ((sv_a / sv_b) > 16'd255);
                n.q   = (n.dz || n.ovf) ? 8'hFF : 8'(sv_a / sv_b);
                pend.push_back(n);
                m_ptr = sv_g;
                e_cnt = e_cnt + 16'd1;
            end
        end
        chk("rsp_valid", rsp_valid, e_rsp_valid);
        chk("rsp_id", rsp_id, e_rsp_id);
        chk("rsp_q", rsp_q, e_rsp_q);
        chk("rsp_dz", rsp_dz, e_dz);
        chk("rsp_ovf", rsp_ovf, e_ovf);
        chk("inflight", inflight, pend.size());
        chk("issue_cnt", issue_cnt, e_cnt);
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    // Requesters keep valid and operands until granted.
    task automatic rnd_drive(input bit all_valid);
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && sv_g != i) continue;
            req_valid[i] = all_valid ? 1'b1 : ($urandom_range(0, 2) != 0);
            a_arr[i] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 4095));
            b_arr[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        end
    endtask

    task automatic issue_one(input int i, input logic [15:0] a, input logic [7:0] b);
        a_arr[i] = a;
        b_arr[i] = b;
        req_valid = NREQ'(1) << i;
        cycle();
        req_valid = '0;
        repeat (LAT) cycle();
    endtask

    initial begin
        bit seen_max;
        bit wrapped;
        rst = 1'b1; hold = 1'b0; req_valid = '0;
        for (int i = 0; i < NREQ; i++) begin a_arr[i] = 16'h0000; b_arr[i] = 8'h00; end
        m_ptr = NREQ - 1; cyc = 0; e_cnt = 16'h0000; e_rsp_valid = '0;
        e_rsp_id = 0; e_rsp_q = 8'h00; e_dz = 1'b0; e_ovf = 1'b0; sv_g = -1;

        repeat (2) cycle();
        chk("reset_inflight", inflight, 32'd0);
        chk("reset_issue_cnt", issue_cnt, 32'd0);
        chk("reset_rsp_valid", rsp_valid, 32'd0);
        rst = 1'b0;

        // Single issue from requester 0.
        a_arr[0] = 16'd1000; b_arr[0] = 8'd7; req_valid = 4'b0001;
        settle();
        chk("single_grant", req_ready, 32'h1);
        tick();
        chk("single_inflight1", inflight, 32'd1);
        req_valid = '0;
        repeat (3) begin cycle(); chk("single_early_rsp", rsp_valid, 32'd0); end
        cycle();
        chk("single_rsp_valid", rsp_valid, 32'h1);
        chk("single_rsp_q", rsp_q, 32'h8E);
        chk("single_inflight0", inflight, 32'd0);
        chk("single_issue_cnt", issue_cnt, 32'd1);

        // Round robin with all requesters valid.
        rst = 1'b1; repeat (2) cycle(); rst = 1'b0;
        a_arr[0] = 16'h0100; b_arr[0] = 8'h03;
        a_arr[1] = 16'h1234; b_arr[1] = 8'h40;
        a_arr[2] = 16'h0FFF; b_arr[2] = 8'h20;
        a_arr[3] = 16'h0005; b_arr[3] = 8'h05;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("rr_grant", req_ready, 32'd1 << (k % NREQ));
            tick();
            if (k == 3) chk("rr_inflight_peak", inflight, 32'd4);
            if (k == 4) chk("rr_first_rsp_id", rsp_id, 32'd0);
        end
        req_valid = '0;
        cycle();
        chk("rr_rsp1_valid", rsp_valid, 32'h2);
        chk("rr_rsp1_id", rsp_id, 32'd1);
        chk("rr_rsp1_q", rsp_q, 32'h48);
        repeat (4) cycle();
        chk("rr_drained", inflight, 32'd0);

        // Overflow and divide-by-zero flags.
        issue_one(0, 16'h8000, 8'h10);
        chk("ovf_flag", rsp_ovf, 32'd1);
        chk("ovf_dz", rsp_dz, 32'd0);
        chk("ovf_q", rsp_q, 32'hFF);
        issue_one(3, 16'h00FF, 8'h00);
        chk("dz_valid", rsp_valid, 32'h8);
        chk("dz_flag", rsp_dz, 32'd1);
        chk("dz_ovf", rsp_ovf, 32'd0);
        chk("dz_q", rsp_q, 32'hFF);

        // Hold blocks grants.
        hold = 1'b1; a_arr[2] = 16'h0640; b_arr[2] = 8'h10; req_valid = 4'b0100;
        repeat (3) begin
            settle();
            chk("hold_ready", req_ready, 32'd0);
            chk("hold_div_a", div_a, 32'd0);
            tick();
            chk("hold_no_rsp", rsp_valid, 32'd0);
        end
        hold = 1'b0;
        settle();
        chk("hold_release_grant", req_ready, 32'h4);
        tick();
        req_valid = '0;
        repeat (LAT) cycle();
        chk("hold_rsp_valid", rsp_valid, 32'h4);
        chk("hold_rsp_q", rsp_q, 32'h64);

        // Reset with three operations in flight.
        req_valid = 4'b1111;
        repeat (3) cycle();
        req_valid = '0; rst = 1'b1;
        cycle();
        req_valid = 4'b1111;
        cycle();
        rst = 1'b0; req_valid = '0;
        repeat (6) begin cycle(); chk("midrst_no_rsp", rsp_valid, 32'd0); end
        chk("midrst_inflight", inflight, 32'd0);
        req_valid = 4'b1111;
        settle();
        chk("midrst_first_grant", req_ready, 32'h1);
        tick();
        req_valid = '0;
        repeat (LAT) cycle();

        // Randomized traffic with occasional hold and reset.
        for (int n = 0; n < 2000; n++) begin
            hold = ($urandom_range(0, 7) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            rnd_drive(1'b0);
            cycle();
        end
        rst = 1'b0; hold = 1'b0;

        // Saturating traffic until issue_cnt wraps.
        seen_max = 1'b0; wrapped = 1'b0;
        for (int n = 0; n < 70000 && !wrapped; n++) begin
            rnd_drive(1'b1);
            cycle();
            if (e_cnt == 16'hFFFF) begin
                chk("wrap_max", issue_cnt, 32'hFFFF);
                seen_max = 1'b1;
            end else if (seen_max && e_cnt == 16'h0000) begin
                chk("wrap_zero", issue_cnt, 32'h0);
                wrapped = 1'b1;
            end
        end
        if (!wrapped) begin
            n_vec++;
            n_fail++;
            $display("FAIL wrap_reached: issue_cnt %0h never wrapped", issue_cnt);
        end
        req_valid = '0;
        repeat (LAT + 2) cycle();
        chk("final_inflight", inflight, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
